// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths, rest code, state encoding and note helpers
package music_pkg;

    localparam int TN_W  = 11;
    localparam int LEN_W = 4;

    localparam logic [TN_W-1:0] REST_CODE = 11'd2047;
    localparam logic [TN_W-1:0] TN_MAX    = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // High octave halves the remaining count span by shifting the preset up.
    function automatic logic [TN_W-1:0] eff_preset(input logic [TN_W-1:0] tn, input logic h);
        return h ? {1'b1, tn[TN_W-1:1]} : tn;
    endfunction

    function automatic logic [LEN_W:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    endfunction

endpackage

// File: rtl/tone_div.sv
// rtl/tone_div.sv - reloadable up-counter divider with square-wave toggle output
module tone_div
    import music_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            load_i,
    input  logic [TN_W-1:0] preset_i,
    output logic            spks_o
);

    logic [TN_W-1:0] cnt_q, cnt_d;
    logic            spks_q, spks_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            spks_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            spks_q <= spks_d;
        end
    end

    // Load both starts a note and silences the output on exit.
    always_comb begin
        cnt_d  = cnt_q;
        spks_d = spks_q;
        if (load_i) begin
            cnt_d  = preset_i;
            spks_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == TN_MAX) begin
                cnt_d  = preset_i;
                spks_d = ~spks_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign spks_o = spks_q;

endmodule

// File: rtl/tone_spker_gen.sv
// rtl/tone_spker_gen.sv - note handshake, beat counting and speaker drive
module tone_spker_gen
    import music_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [TN_W-1:0]  TN,
    input  logic             H,
    input  logic [LEN_W-1:0] LEN,
    input  logic             NOTE_VALID,
    output logic             NOTE_READY,
    input  logic             BEAT_TICK,
    input  logic             STOP,
    output logic             SPKS,
    output logic             BUSY,
    output logic             DONE,
    output logic             HIGH_LED
);

    localparam logic [LEN_W:0] BEAT_ONE = 1;

    state_e           state_q, state_d;
    logic [TN_W-1:0]  tn_q;
    logic             h_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_q;
    logic             done_q;

    logic             note_ready, busy, accept, play_exit, done_d;
    logic             tick_final, rest;
    logic             div_en, div_load;
    logic [TN_W-1:0]  div_preset;

    assign tick_final = BEAT_TICK && ((beat_q + BEAT_ONE) == eff_len(len_q));
    assign rest       = (tn_q == REST_CODE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (NOTE_VALID && !STOP) state_d = ST_PLAY;
            ST_PLAY: if (STOP || tick_final) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // STOP beats a coincident final tick, so done_d needs !STOP.
    always_comb begin
        note_ready = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        play_exit  = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                note_ready = !STOP;
                accept     = NOTE_VALID && !STOP;
            end
            ST_PLAY: begin
                busy      = 1'b1;
                play_exit = STOP || tick_final;
                done_d    = tick_final && !STOP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tn_q   <= '0;
            h_q    <= 1'b0;
            len_q  <= '0;
            beat_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (accept) begin
                tn_q   <= TN;
                h_q    <= H;
                len_q  <= LEN;
                beat_q <= '0;
            end else if (play_exit) begin
                h_q    <= 1'b0;
                beat_q <= '0;
            end else if (busy && BEAT_TICK) begin
                beat_q <= beat_q + BEAT_ONE;
            end
        end
    end

    assign div_load   = accept || play_exit;
    assign div_en     = busy && !rest;
    assign div_preset = accept ? eff_preset(TN, H) : eff_preset(tn_q, h_q);

    tone_div u_div (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .en_i     (div_en),
        .load_i   (div_load),
        .preset_i (div_preset),
        .spks_o   (SPKS)
    );

    assign NOTE_READY = note_ready;
    assign BUSY       = busy;
    assign DONE       = done_q;
    assign HIGH_LED   = h_q;

endmodule

// File: tb/tb_tone_spker_gen.sv
// tb/tb_tone_spker_gen.sv - bench for tone_spker_gen with behavioural note model
module tb_tone_spker_gen;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [10:0] TN = '0;
    logic        H = 1'b0;
    logic [3:0]  LEN = '0;
    logic        NOTE_VALID = 1'b0;
    logic        BEAT_TICK = 1'b0;
    logic        STOP = 1'b0;
    logic        NOTE_READY, SPKS, BUSY, DONE, HIGH_LED;

    int vec = 0;
    int err = 0;

    bit m_play = 0, m_h = 0, m_done = 0;
    int m_tn = 0, m_len = 0, m_beats = 0, m_t = 0;

    logic s_h [0:399];
    logic d_h [0:399];
    logic b_h [0:399];
    logic l_h [0:399];
    logic r_h [0:399];

    tone_spker_gen dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TN         (TN),
        .H          (H),
        .LEN        (LEN),
        .NOTE_VALID (NOTE_VALID),
        .NOTE_READY (NOTE_READY),
        .BEAT_TICK  (BEAT_TICK),
        .STOP       (STOP),
        .SPKS       (SPKS),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .HIGH_LED   (HIGH_LED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_play = 0; m_h = 0; m_done = 0; m_tn = 0; m_len = 0; m_beats = 0; m_t = 0;
    endtask

    // One clock: drive, compare against the note model, then advance the model.
    task automatic cyc(input bit v, input int tn, input bit h, input int len,
                       input bit tick, input bit stop);
        int p, half;
        bit exp_spk;
        @(negedge CLK);
        NOTE_VALID = v; TN = 11'(tn); H = h; LEN = 4'(len); BEAT_TICK = tick; STOP = stop;
        #1;
        p = m_h ? 1024 + m_tn / 2 : m_tn;
        half = 2048 - p;
        exp_spk = m_play && (m_tn != 2047) && (((m_t / half) % 2) == 1);
        chk("spks", SPKS, exp_spk);
        chk("busy", BUSY, m_play);
        chk("done", DONE, m_done);
        chk("high_led", HIGH_LED, m_play && m_h);
        chk("note_ready", NOTE_READY, !m_play && !stop);
        m_done = 0;
        if (!m_play) begin
            if (v && !stop) begin
                m_play = 1; m_tn = tn; m_h = h; m_len = (len == 0) ? 16 : len;
                m_beats = 0; m_t = 0;
            end
        end else begin
            m_t++;
            if (stop) m_play = 0;
            else if (tick) begin
                m_beats++;
                if (m_beats == m_len) begin
                    m_play = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic rec(input int k);
        s_h[k] = SPKS; d_h[k] = DONE; b_h[k] = BUSY; l_h[k] = HIGH_LED; r_h[k] = NOTE_READY;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_spks", SPKS, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_hled", HIGH_LED, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("ready_after_rst", NOTE_READY, 1'b1);

        // Basic tone: half-period 8, two beats
        cyc(1, 2040, 0, 2, 0, 0);
        for (int k = 0; k <= 40; k++) begin
            cyc(0, 0, 0, 0, (k == 20) || (k == 30), 0);
            rec(k);
        end
        chk("basic_s7", s_h[7], 1'b0);
        chk("basic_s8", s_h[8], 1'b1);
        chk("basic_s15", s_h[15], 1'b1);
        chk("basic_s16", s_h[16], 1'b0);
        chk("basic_s24", s_h[24], 1'b1);
        chk("basic_busy30", b_h[30], 1'b1);
        chk("basic_done31", d_h[31], 1'b1);
        chk("basic_s31", s_h[31], 1'b0);
        chk("basic_ready31", r_h[31], 1'b1);
        chk("basic_done32", d_h[32], 1'b0);

        // High octave: P=2044, half-period 4
        cyc(1, 2040, 1, 1, 0, 0);
        for (int k = 0; k <= 12; k++) begin
            cyc(0, 0, 0, 0, k == 10, 0);
            rec(k);
        end
        chk("hi_s3", s_h[3], 1'b0);
        chk("hi_s4", s_h[4], 1'b1);
        chk("hi_s8", s_h[8], 1'b0);
        chk("hi_led0", l_h[0], 1'b1);
        chk("hi_led10", l_h[10], 1'b1);
        chk("hi_led11", l_h[11], 1'b0);
        chk("hi_done11", d_h[11], 1'b1);

        // Rest with a tick in the acceptance cycle
        cyc(1, 2047, 1, 3, 1, 0);
        for (int k = 0; k <= 8; k++) begin
            cyc(0, 0, 0, 0, (k == 2) || (k == 4) || (k == 6), 0);
            rec(k);
        end
        chk("rest_done5", d_h[5], 1'b0);
        chk("rest_busy6", b_h[6], 1'b1);
        chk("rest_s3", s_h[3], 1'b0);
        chk("rest_done7", d_h[7], 1'b1);

        // LEN=0 means 16 beats; NOTE_VALID held high throughout
        cyc(1, 2000, 0, 0, 0, 0);
        for (int k = 0; k <= 49; k++) begin
            cyc(1, 2000, 0, 0, (k % 3 == 1) && (k <= 46), 0);
            rec(k);
        end
        chk("len0_done44", d_h[44], 1'b0);
        chk("len0_busy44", b_h[44], 1'b1);
        chk("len0_ready20", r_h[20], 1'b0);
        chk("len0_done47", d_h[47], 1'b1);
        chk("len0_ready47", r_h[47], 1'b1);
        chk("len0_busy48", b_h[48], 1'b1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // STOP mid-note
        cyc(1, 2040, 0, 2, 0, 0);
        for (int k = 0; k <= 8; k++) begin
            cyc(0, 0, 0, 0, k == 3, k == 6);
            rec(k);
        end
        chk("stop_busy7", b_h[7], 1'b0);
        chk("stop_done7", d_h[7], 1'b0);
        chk("stop_s7", s_h[7], 1'b0);
        // Final tick coincident with STOP
        cyc(1, 2040, 0, 2, 0, 0);
        for (int k = 0; k <= 8; k++) begin
            cyc(0, 0, 0, 0, (k == 2) || (k == 5), k == 5);
            rec(k);
        end
        chk("stoptick_busy6", b_h[6], 1'b0);
        chk("stoptick_done6", d_h[6], 1'b0);
        // STOP in IDLE blocks acceptance
        cyc(1, 2040, 0, 2, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("idle_stop_block", BUSY, 1'b0);

        // Asynchronous reset mid-note
        cyc(1, 2000, 1, 5, 0, 0);
        for (int k = 0; k <= 30; k++) cyc(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        #2;
        chk("pre_rst_spks", SPKS, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("arst_spks", SPKS, 1'b0);
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_hled", HIGH_LED, 1'b0);
        chk("arst_done", DONE, 1'b0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        cyc(1, 1900, 0, 1, 0, 0);
        for (int k = 0; k <= 300; k++) begin
            cyc(0, 0, 0, 0, k == 300, 0);
            rec(k);
        end
        chk("t1900_s147", s_h[147], 1'b0);
        chk("t1900_s148", s_h[148], 1'b1);
        chk("t1900_s295", s_h[295], 1'b1);
        chk("t1900_s296", s_h[296], 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int tn;
            tn = ($urandom_range(5, 0) == 0) ? 2047 : int'($urandom_range(2047, 1900));
            cyc($urandom_range(1, 0) == 1, tn, $urandom_range(1, 0) == 1,
                int'($urandom_range(15, 0)), $urandom_range(7, 0) == 0,
                $urandom_range(59, 0) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
